// File: rtl/cn_c2v_gen.sv
// cn_c2v_gen: per-row compressed check-node state store and C2V message regenerator
// Ports: i_clk/i_rst_n clock and async active-low reset; i_flush unseeds all rows;
//   i_upd_* writes {min2,min1}, min1 column, total sign of a row;
//   i_req_* asks for the C2V of a row/column; o_c2v_* returns it 2 cycles later.
// Define C2V_SCALE_EN for normalized (3/4) min-sum instead of offset min-sum.
module cn_c2v_gen #(
  parameter int MSG_WIDTH   = 6,
  parameter int COL_CNT_WID = 7,
  parameter int ROW_NUM     = 16,
  parameter int ROW_WID     = 4,
  parameter int OFFSET      = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_upd_vld,
  input  logic [ROW_WID-1:0]         i_upd_row,
  input  logic [(MSG_WIDTH-1)*2-1:0] i_upd_abs,
  input  logic [COL_CNT_WID-1:0]     i_upd_idx,
  input  logic                       i_upd_sign_tot,
  input  logic                       i_req_vld,
  input  logic [ROW_WID-1:0]         i_req_row,
  input  logic [COL_CNT_WID-1:0]     i_req_col,
  input  logic                       i_req_sign,
  output logic                       o_c2v_vld,
  output logic [MSG_WIDTH-1:0]       o_c2v,
  output logic [ROW_WID-1:0]         o_c2v_row
);
  localparam int M  = MSG_WIDTH - 1;
  localparam int RN = 2 ** ROW_WID;
  // one bit per addressable row: set where the row actually exists
  localparam logic [RN-1:0] ROW_OK = {RN{1'b1}} >> (RN - ROW_NUM);
  logic [M-1:0]           min1_q [RN], min1_d [RN], min2_q [RN], min2_d [RN];
  logic [COL_CNT_WID-1:0] idx_q [RN], idx_d [RN];
  logic [RN-1:0]          sgn_q, sgn_d, seed_q, seed_d;
  logic                   s1_vld_q, s1_vld_d, s1_seed_q, s1_seed_d, s1_sgn_q, s1_sgn_d;
  logic                   s1_rsgn_q, s1_rsgn_d;
  logic [M-1:0]           s1_min1_q, s1_min1_d, s1_min2_q, s1_min2_d;
  logic [COL_CNT_WID-1:0] s1_idx_q, s1_idx_d, s1_col_q, s1_col_d;
  logic [ROW_WID-1:0]     s1_row_q, s1_row_d, c2v_row_q, c2v_row_d;
  logic                   c2v_vld_q, c2v_vld_d;
  logic [MSG_WIDTH-1:0]   c2v_q, c2v_d;
  logic                   upd_ok, byp;
  logic [M-1:0]           mag, corr;
  logic [M+1:0]           mag3;
  assign upd_ok = i_upd_vld && ROW_OK[i_upd_row];
  // a same-cycle update of the requested row is forwarded so the request sees the new state
  assign byp    = upd_ok && (i_upd_row == i_req_row);
  always_comb begin
    min1_d = min1_q;
    min2_d = min2_q;
    idx_d  = idx_q;
    sgn_d  = sgn_q;
    seed_d = i_flush ? '0 : seed_q;
    if (upd_ok) begin
      min1_d[i_upd_row] = i_upd_abs[M-1:0];
      min2_d[i_upd_row] = i_upd_abs[2*M-1:M];
      idx_d[i_upd_row]  = i_upd_idx;
      sgn_d[i_upd_row]  = i_upd_sign_tot;
      seed_d[i_upd_row] = 1'b1;
    end
  end
  always_comb begin
    s1_vld_d  = i_req_vld;
    s1_min1_d = byp ? i_upd_abs[M-1:0] : min1_q[i_req_row];
    s1_min2_d = byp ? i_upd_abs[2*M-1:M] : min2_q[i_req_row];
    s1_idx_d  = byp ? i_upd_idx : idx_q[i_req_row];
    s1_sgn_d  = byp ? i_upd_sign_tot : sgn_q[i_req_row];
    s1_seed_d = byp || (ROW_OK[i_req_row] && !i_flush && seed_q[i_req_row]);
    s1_col_d  = i_req_col;
    s1_rsgn_d = i_req_sign;
    s1_row_d  = i_req_row;
  end
  always_comb begin
    mag  = (s1_col_q == s1_idx_q) ? s1_min2_q : s1_min1_q;
    mag3 = {2'b00, mag} + {1'b0, mag, 1'b0};
`ifdef C2V_SCALE_EN
    corr = mag3[M+1:2];
`else
    corr = (mag > M'(OFFSET)) ? mag - M'(OFFSET) : '0;
`endif
    c2v_d     = s1_seed_q ? {(s1_sgn_q ^ s1_rsgn_q) && (|corr), corr} : '0;
    c2v_vld_d = s1_vld_q;
    c2v_row_d = s1_row_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      min1_q    <= '{default: '1};
      min2_q    <= '{default: '1};
      idx_q     <= '{default: '1};
      sgn_q     <= '0;
      seed_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_seed_q <= 1'b0;
      s1_sgn_q  <= 1'b0;
      s1_rsgn_q <= 1'b0;
      s1_min1_q <= '0;
      s1_min2_q <= '0;
      s1_idx_q  <= '0;
      s1_col_q  <= '0;
      s1_row_q  <= '0;
      c2v_vld_q <= 1'b0;
      c2v_q     <= '0;
      c2v_row_q <= '0;
    end else begin
      min1_q    <= min1_d;
      min2_q    <= min2_d;
      idx_q     <= idx_d;
      sgn_q     <= sgn_d;
      seed_q    <= seed_d;
      s1_vld_q  <= s1_vld_d;
      s1_seed_q <= s1_seed_d;
      s1_sgn_q  <= s1_sgn_d;
      s1_rsgn_q <= s1_rsgn_d;
      s1_min1_q <= s1_min1_d;
      s1_min2_q <= s1_min2_d;
      s1_idx_q  <= s1_idx_d;
      s1_col_q  <= s1_col_d;
      s1_row_q  <= s1_row_d;
      c2v_vld_q <= c2v_vld_d;
      c2v_q     <= c2v_d;
      c2v_row_q <= c2v_row_d;
    end
  end
  assign o_c2v_vld = c2v_vld_q;
  assign o_c2v     = c2v_q;
  assign o_c2v_row = c2v_row_q;
endmodule

// File: tb/tb_cn_c2v_gen.sv
// tb_cn_c2v_gen: directed stimulus, behavioural row-table model and literal checks for cn_c2v_gen
module tb_cn_c2v_gen;
  localparam int ROW_NUM = 16;
  localparam int OFFSET  = 1;
  logic       i_clk = 1'b0, i_rst_n = 1'b0, i_flush = 1'b0;
  logic       i_upd_vld = 1'b0, i_upd_sign_tot = 1'b0;
  logic [3:0] i_upd_row = '0, i_req_row = '0, o_c2v_row;
  logic [9:0] i_upd_abs = '0;
  logic [6:0] i_upd_idx = '0, i_req_col = '0;
  logic       i_req_vld = 1'b0, i_req_sign = 1'b0, o_c2v_vld;
  logic [5:0] o_c2v;
  int n_vec = 0, n_bad = 0, cyc = 0;
  typedef struct {int due; logic [5:0] val; logic [3:0] row;} exp_t;
  exp_t q[$];
  int m1 [ROW_NUM], m2 [ROW_NUM], ix [ROW_NUM], st [ROW_NUM];
  bit sd [ROW_NUM];
  bit ev;
  cn_c2v_gen dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_upd_vld(i_upd_vld), .i_upd_row(i_upd_row), .i_upd_abs(i_upd_abs),
    .i_upd_idx(i_upd_idx), .i_upd_sign_tot(i_upd_sign_tot),
    .i_req_vld(i_req_vld), .i_req_row(i_req_row), .i_req_col(i_req_col),
    .i_req_sign(i_req_sign), .o_c2v_vld(o_c2v_vld), .o_c2v(o_c2v), .o_c2v_row(o_c2v_row)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [5:0] c2v(int r, int col, int rs);
    int mag, corr;
    bit s;
    if (r >= ROW_NUM || !sd[r]) return 6'd0;
    mag = (col == ix[r]) ? m2[r] : m1[r];
`ifdef C2V_SCALE_EN
    corr = (3 * mag) / 4;
`else
    corr = (mag > OFFSET) ? mag - OFFSET : 0;
`endif
    s = (corr != 0) && (st[r] != rs);
    return {s, 5'(corr)};
  endfunction
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q.delete();
      for (int r = 0; r < ROW_NUM; r++) sd[r] = 1'b0;
    end else begin
      cyc++;
      if (i_flush) for (int r = 0; r < ROW_NUM; r++) sd[r] = 1'b0;
      if (i_upd_vld && int'(i_upd_row) < ROW_NUM) begin
        m1[i_upd_row] = int'(i_upd_abs[4:0]);
        m2[i_upd_row] = int'(i_upd_abs[9:5]);
        ix[i_upd_row] = int'(i_upd_idx);
        st[i_upd_row] = int'(i_upd_sign_tot);
        sd[i_upd_row] = 1'b1;
      end
      if (i_req_vld)
        q.push_back('{cyc + 1, c2v(int'(i_req_row), int'(i_req_col), int'(i_req_sign)), i_req_row});
    end
  end
  always @(negedge i_clk) begin
    n_vec++;
    if (!i_rst_n) begin
      if (o_c2v_vld !== 1'b0 || o_c2v !== 6'h00 || o_c2v_row !== 4'h0) begin
        n_bad++;
        $display("FAIL reset_outs: vld=%b c2v=%h row=%h, need all 0", o_c2v_vld, o_c2v, o_c2v_row);
      end
    end else begin
      ev = q.size() > 0 && q[0].due == cyc;
      if (o_c2v_vld !== ev) begin
        n_bad++;
        $display("FAIL vld cyc %0d: got %b need %b", cyc, o_c2v_vld, ev);
      end else if (ev && (o_c2v !== q[0].val || o_c2v_row !== q[0].row)) begin
        n_bad++;
        $display("FAIL data cyc %0d: got c2v=%h row=%h need c2v=%h row=%h",
                 cyc, o_c2v, o_c2v_row, q[0].val, q[0].row);
      end
      if (ev) void'(q.pop_front());
    end
  end
  task automatic tick();
    @(posedge i_clk);
    #1;
    i_upd_vld = 1'b0;
    i_req_vld = 1'b0;
    i_flush   = 1'b0;
  endtask
  task automatic upd(int r, int mn1, int mn2, int idx, int s);
    i_upd_vld = 1'b1; i_upd_row = 4'(r); i_upd_abs = {5'(mn2), 5'(mn1)};
    i_upd_idx = 7'(idx); i_upd_sign_tot = s[0];
  endtask
  task automatic req(int r, int col, int s);
    i_req_vld = 1'b1; i_req_row = 4'(r); i_req_col = 7'(col); i_req_sign = s[0];
  endtask
  task automatic lit(string name, logic [5:0] exp);
    @(posedge i_clk);
    #2;
    n_vec++;
    if (o_c2v_vld !== 1'b1 || o_c2v !== exp) begin
      n_bad++;
      $display("FAIL %s: got vld=%b c2v=%h need vld=1 c2v=%h", name, o_c2v_vld, o_c2v, exp);
    end
  endtask
`ifdef C2V_SCALE_EN
  localparam logic [5:0] E_R2C17 = 6'h26, E_R2C3 = 6'h03, E_BYP = 6'h04, E_FU = 6'h2F;
`else
  localparam logic [5:0] E_R2C17 = 6'h28, E_R2C3 = 6'h04, E_BYP = 6'h05, E_FU = 6'h33;
`endif
  int tr [10] = '{2, 2, 8, 8, 9, 9, 4, 4, 2, 13};
  int tc [10] = '{17, 17, 0, 5, 6, 7, 0, 1, 3, 0};
  int ts [10] = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 1};
  initial begin
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    req(3, 0, 0); tick(); lit("rst_row3", 6'h00);
    upd(2, 5, 9, 17, 1); tick();
    req(2, 17, 0); tick(); lit("r2_c17", E_R2C17);
    req(2, 3, 1); tick(); lit("r2_c3", E_R2C3);
    upd(5, 0, 1, 4, 1); tick();
    req(5, 9, 0); tick(); lit("r5_c9_negzero", 6'h00);
    req(5, 4, 0); tick(); lit("r5_c4_min2", 6'h00);
    upd(7, 6, 10, 1, 0); req(7, 2, 0); tick(); lit("bypass_r7", E_BYP);
    upd(8, 3, 4, 0, 1); tick(); req(8, 5, 1); tick(); tick();
    i_flush = 1'b1; tick();
    req(7, 2, 0); tick(); lit("flushed_r7", 6'h00);
    i_flush = 1'b1; upd(9, 12, 20, 6, 0); tick();
    req(9, 6, 1); tick(); lit("flush_upd_r9", E_FU);
    upd(4, 31, 31, 0, 0); tick();
    upd(8, 2, 7, 5, 0); tick();
    for (int i = 0; i < 10; i++) begin
      req(tr[i], tc[i], ts[i]);
      tick();
    end
    upd(2, 5, 9, 17, 1); tick();
    upd(5, 0, 1, 4, 1); tick();
    req(2, 17, 0); tick();
    req(5, 9, 0); #2 i_rst_n = 1'b0;
    req(2, 17, 0);
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1; i_req_vld = 1'b0;
    repeat (4) tick();
    req(2, 17, 0); tick(); lit("post_rst_r2", 6'h00);
    req(5, 4, 0); tick(); lit("post_rst_r5", 6'h00);
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
endmodule
